// File: rtl/uart_word_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_word_rx
//  Description : 8N1 UART receiver that packs BIT_WIDTH/8 consecutive bytes
//                (first byte in the low lane) into one word with a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int BIT_WIDTH    = 32,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [BIT_WIDTH-1:0] UART_DATA,
  output logic                 W_UART,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int NBYTES   = BIT_WIDTH / 8;
  localparam int IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 rxs_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_idx_q;
  logic [IW-1:0]        byte_idx_q;
  logic [TW-1:0]        to_cnt_q;
  logic [7:0]           shift_q;
  logic [BIT_WIDTH-1:0] asm_q;
  logic [BIT_WIDTH-1:0] asm_d;
  logic                 last_byte;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      rxs_q   <= sync1_q;
    end
  end

  // Assembly register with the current byte dropped into lane byte_idx_q
  always_comb begin
    asm_d = asm_q;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_idx_q == IW'(b)) asm_d[8*b +: 8] = shift_q;
    end
  end

  assign last_byte = (byte_idx_q == IW'(NBYTES - 1));
  assign busy      = (state_q != S_IDLE);

  // Receive FSM: frame timing, byte assembly, word strobe and idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      to_cnt_q   <= '0;
      shift_q    <= '0;
      asm_q      <= '0;
      UART_DATA  <= '0;
      W_UART     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      W_UART    <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rxs_q) begin
            state_q  <= S_START;
            to_cnt_q <= '0;
          end else if (byte_idx_q != '0) begin
            // A partial word left idle too long is dropped without notice
            if (to_cnt_q == TW'(TO_LIMIT - 1)) begin
              byte_idx_q <= '0;
              to_cnt_q   <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end else begin
            to_cnt_q <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects short glitches on the line
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q   <= '0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxs_q;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (rxs_q) begin
              asm_q <= asm_d;
              if (last_byte) begin
                UART_DATA  <= asm_d;
                W_UART     <= 1'b1;
                byte_idx_q <= '0;
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end else begin
              // Bad stop bit: drop the byte and restart word alignment
              frame_err  <= 1'b1;
              byte_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit period; the legal minimum is 4.
REQ-002 SHALL provide parameter BIT_WIDTH, default 32, giving the width of the assembled word; it SHALL be a multiple of 8.
REQ-003 SHALL provide parameter TIMEOUT_BITS, default 20, giving the idle bit-periods after which a partial word is discarded.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx_serial, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port UART_DATA, output, BIT_WIDTH bits: the last complete assembled word, feeding the processor GPIO input.
REQ-008 SHALL have port W_UART, output, 1 bit: a one-cycle strobe marking a new UART_DATA word.
REQ-009 SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a bad stop bit is sampled.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass rx_serial through a 2-flop synchronizer; both flops reset to 1; all logic below uses the synchronized value rxs.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, plus a bit-period counter (0..CLKS_PER_BIT-1), a bit index (0..7), a byte index (0..BIT_WIDTH/8-1) and an idle-timeout counter.
REQ-013 IDLE: rxs==0 SHALL move the FSM to START with the bit-period counter cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles, the FSM SHALL sample rxs; if 0, go to DATA with the counter cleared; if 1 (glitch), return to IDLE with no output activity.
REQ-015 DATA: every CLKS_PER_BIT cycles, the FSM SHALL sample rxs into the byte shift register at the bit index (LSB first); after bit 7, go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, the FSM SHALL sample rxs and return to IDLE on the next edge, regardless of the sampled value.
REQ-017 A stop bit sampled as 1 SHALL write the byte into the word assembly register at bits [8*k+7:8*k], where k is the byte index, and SHALL then increment k.
REQ-018 When k==BIT_WIDTH/8-1 and the stop bit is valid, UART_DATA SHALL load the full assembled word and W_UART SHALL be 1 in the cycle after the stop sample; k SHALL wrap to 0.
REQ-019 A stop bit sampled as 0 SHALL raise frame_err for exactly 1 cycle (the cycle after the sample), discard the byte, and reset k to 0 without changing UART_DATA or raising W_UART.
REQ-020 UART_DATA SHALL hold its value between strobes; W_UART and frame_err SHALL never be high for 2 consecutive cycles.
REQ-021 With k!=0 in IDLE, the timeout counter SHALL count clocks; on reaching TIMEOUT_BITS*CLKS_PER_BIT it SHALL reset k to 0 silently; any start bit SHALL clear the counter.
REQ-022 A start bit arriving in the same cycle the FSM enters IDLE from STOP SHALL be accepted on the following cycle; back-to-back frames with a 1-bit stop SHALL be received without loss.
REQ-023 Total latency SHALL be exactly 2 synchronizer cycles plus 9.5 bit periods from the start-bit falling edge to the stop sample, plus 1 cycle to the strobe.

Reset
REQ-024 While rst==1, the block SHALL set FSM=IDLE, all counters=0, the assembly register=0, UART_DATA=0, W_UART=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-025 Asserting rst mid-frame SHALL abandon the partial byte and partial word; after release, the block SHALL wait for a fresh falling edge.

Verification
REQ-026 Bytes 0x05,0x00,0x00,0x00 with CLKS_PER_BIT=16 -> exactly one W_UART pulse; UART_DATA=0x00000005; busy low afterwards.
REQ-027 Bytes 0xEF,0xBE,0xAD,0xDE sent back-to-back with no idle gap -> UART_DATA=0xDEADBEEF; one strobe, arriving 1 cycle after the 4th stop sample.
REQ-028 rx_serial low for 3 clocks, then high -> FSM returns to IDLE; no W_UART or frame_err pulse; k unchanged.
REQ-029 2nd byte sent with stop bit 0 -> frame_err pulses once; subsequent bytes 0x11,0x22,0x33,0x44 -> UART_DATA=0x44332211.
REQ-030 Send 2 bytes, idle for 21 bit periods, then send 0x01,0x02,0x03,0x04 -> UART_DATA=0x04030201 with no stale bytes included.
REQ-031 rst pulsed during the DATA state of the 3rd byte -> all outputs 0; the next 4 clean bytes produce a correct word and a single strobe.
